// File: rtl/stack_up_pkg.sv
// Shared definitions for the stack-upstream (PE -> stack) interface.
package stack_up_pkg;

  localparam int unsigned STU_TYPE_W = 2;
  localparam int unsigned STU_DATA_W = 64;
  localparam int unsigned STU_OOB_W  = 32;

  localparam logic [1:0] STU_CNTL_MOM     = 2'b00;
  localparam logic [1:0] STU_CNTL_SOM     = 2'b01;
  localparam logic [1:0] STU_CNTL_EOM     = 2'b10;
  localparam logic [1:0] STU_CNTL_SOM_EOM = 2'b11;

  typedef struct packed {
    logic [1:0]            cntl;
    logic [STU_TYPE_W-1:0] btype;
    logic [STU_DATA_W-1:0] data;
    logic [STU_OOB_W-1:0]  oob;
  } stu_beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } stu_rx_state_e;

endpackage

// File: rtl/stu_rx_fifo.sv
// Synchronous FIFO of beats with a registered head stage.
//   push/wr_data       : write side (accepted when not full, or full with a pop)
//   pop                : consume head (ignored when empty)
//   rd_valid/rd_data   : registered head; rd_data holds its last value when empty
//   count/count_next   : occupancy now / after this cycle's push and pop
//   full/empty         : decoded from count
module stu_rx_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter type         beat_t = stack_up_pkg::stu_beat_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  beat_t                    wr_data,
  input  logic                     pop,
  output logic                     rd_valid,
  output beat_t                    rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  beat_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  beat_t           head_q, head_d;
  logic            valid_q, valid_d;
  logic            do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);

    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Head is preloaded from next-cycle storage; a beat written this cycle
    // into the slot that becomes the head bypasses the memory.
    valid_d = (count_d != '0);
    head_d  = head_q;
    if (valid_d) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_valid   = valid_q;
  assign rd_data    = head_q;
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/stu_upstream_rx.sv
// Stack-side receiver for the PE upstream bus.
//   pe__stu__*   : beats from the PE, flow-controlled by registered stu__pe__ready
//   stu__sys__*  : FIFO head towards the stack-upstream arbiter (valid/ready)
//   pkt_count    : completed packets (wraps), framing_err : sticky violation flag
module stu_upstream_rx
  import stack_up_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TYPE_W = STU_TYPE_W,
  parameter int unsigned DATA_W = STU_DATA_W,
  parameter int unsigned OOB_W  = STU_OOB_W
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              pe__stu__valid,
  input  logic [1:0]        pe__stu__cntl,
  input  logic [TYPE_W-1:0] pe__stu__type,
  input  logic [DATA_W-1:0] pe__stu__data,
  input  logic [OOB_W-1:0]  pe__stu__oob_data,
  output logic              stu__pe__ready,
  output logic              stu__sys__valid,
  output logic [1:0]        stu__sys__cntl,
  output logic [TYPE_W-1:0] stu__sys__type,
  output logic [DATA_W-1:0] stu__sys__data,
  output logic [OOB_W-1:0]  stu__sys__oob_data,
  input  logic              sys__stu__ready,
  output logic [15:0]       stu__sys__pkt_count,
  output logic              stu__sys__framing_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [1:0]        cntl;
    logic [TYPE_W-1:0] btype;
    logic [DATA_W-1:0] data;
    logic [OOB_W-1:0]  oob;
  } beat_t;

  beat_t          wr_beat, head;
  logic           push, pop, proto_err, head_valid;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count, count_next;

  logic           ready_q, ready_d;
  stu_rx_state_e  state_q, state_d;
  logic           frm_err, pkt_done;
  logic           err_q, err_d;
  logic [15:0]    pkt_count_q, pkt_count_d;

  always_comb begin
    wr_beat.cntl  = pe__stu__cntl;
    wr_beat.btype = pe__stu__type;
    wr_beat.data  = pe__stu__data;
    wr_beat.oob   = pe__stu__oob_data;
    push      = pe__stu__valid && ready_q;
    proto_err = pe__stu__valid && !ready_q;
    pop       = head_valid && sys__stu__ready;
  end

  stu_rx_fifo #(
    .DEPTH  (DEPTH),
    .beat_t (beat_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_poweron),
    .push       (push),
    .wr_data    (wr_beat),
    .pop        (pop),
    .rd_valid   (head_valid),
    .rd_data    (head),
    .count      (fifo_count),
    .count_next (count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Ready looks at post-update occupancy, so a push never meets a full FIFO.
  always_comb begin
    ready_d = (count_next < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (push) begin
      unique case (state_q)
        IDLE:   if (pe__stu__cntl == STU_CNTL_SOM) state_d = IN_PKT;
        IN_PKT: if ((pe__stu__cntl == STU_CNTL_EOM) ||
                    (pe__stu__cntl == STU_CNTL_SOM_EOM)) state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    frm_err  = 1'b0;
    pkt_done = 1'b0;
    if (push) begin
      unique case (state_q)
        IDLE: begin
          frm_err  = (pe__stu__cntl == STU_CNTL_MOM) || (pe__stu__cntl == STU_CNTL_EOM);
          pkt_done = (pe__stu__cntl == STU_CNTL_SOM_EOM);
        end
        IN_PKT: begin
          frm_err  = (pe__stu__cntl == STU_CNTL_SOM) || (pe__stu__cntl == STU_CNTL_SOM_EOM);
          pkt_done = (pe__stu__cntl == STU_CNTL_EOM) || (pe__stu__cntl == STU_CNTL_SOM_EOM);
        end
      endcase
    end
  end

  always_comb begin
    err_d       = err_q | frm_err | proto_err;
    pkt_count_d = pkt_count_q + {15'd0, pkt_done};
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      ready_q     <= ready_d;
      err_q       <= err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign stu__pe__ready        = ready_q;
  assign stu__sys__valid       = head_valid;
  assign stu__sys__cntl        = head.cntl;
  assign stu__sys__type        = head.btype;
  assign stu__sys__data        = head.data;
  assign stu__sys__oob_data    = head.oob;
  assign stu__sys__pkt_count   = pkt_count_q;
  assign stu__sys__framing_err = err_q;

  push_has_room: assert property (@(posedge clk) disable iff (!reset_poweron)
    push |-> (!fifo_full || pop));
  pop_not_empty: assert property (@(posedge clk) disable iff (!reset_poweron)
    pop |-> !fifo_empty);
  count_in_range: assert property (@(posedge clk) disable iff (!reset_poweron)
    fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_stu_upstream_rx.sv
module tb_stu_upstream_rx;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_poweron;
  logic        pe__stu__valid;
  logic [1:0]  pe__stu__cntl;
  logic [1:0]  pe__stu__type;
  logic [63:0] pe__stu__data;
  logic [31:0] pe__stu__oob_data;
  logic        stu__pe__ready;
  logic        stu__sys__valid;
  logic [1:0]  stu__sys__cntl;
  logic [1:0]  stu__sys__type;
  logic [63:0] stu__sys__data;
  logic [31:0] stu__sys__oob_data;
  logic        sys__stu__ready;
  logic [15:0] stu__sys__pkt_count;
  logic        stu__sys__framing_err;

  always #5 clk = ~clk;

  stu_upstream_rx #(
    .DEPTH  (DEPTH),
    .TYPE_W (2),
    .DATA_W (64),
    .OOB_W  (32)
  ) dut (
    .clk                   (clk),
    .reset_poweron         (reset_poweron),
    .pe__stu__valid        (pe__stu__valid),
    .pe__stu__cntl         (pe__stu__cntl),
    .pe__stu__type         (pe__stu__type),
    .pe__stu__data         (pe__stu__data),
    .pe__stu__oob_data     (pe__stu__oob_data),
    .stu__pe__ready        (stu__pe__ready),
    .stu__sys__valid       (stu__sys__valid),
    .stu__sys__cntl        (stu__sys__cntl),
    .stu__sys__type        (stu__sys__type),
    .stu__sys__data        (stu__sys__data),
    .stu__sys__oob_data    (stu__sys__oob_data),
    .sys__stu__ready       (sys__stu__ready),
    .stu__sys__pkt_count   (stu__sys__pkt_count),
    .stu__sys__framing_err (stu__sys__framing_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [63:0] data;
    logic [31:0] oob;
  } tb_beat_t;

  // Reference model: a queue of stored beats plus packet bookkeeping.
  tb_beat_t    mq[$];
  tb_beat_t    m_head;
  bit          m_ready, m_open, m_err;
  int unsigned m_pkt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_head  = '{default: '0};
    m_ready = 1'b0;
    m_open  = 1'b0;
    m_err   = 1'b0;
    m_pkt   = 0;
  endtask

  task automatic model_frame(input logic [1:0] c);
    case (c)
      2'b01: begin if (m_open) m_err = 1'b1; m_open = 1'b1; end
      2'b00: begin if (!m_open) m_err = 1'b1; end
      2'b10: begin
        if (!m_open) m_err = 1'b1;
        else begin m_pkt++; m_open = 1'b0; end
      end
      default: begin if (m_open) m_err = 1'b1; m_pkt++; m_open = 1'b0; end
    endcase
  endtask

  task automatic model_edge(input bit pv, input tb_beat_t b, input bit sr);
    bit push, pop;
    push = pv && m_ready;
    pop  = (mq.size() != 0) && sr;
    if (pv && !m_ready) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(b);
      model_frame(b.cntl);
    end
    m_ready = (mq.size() < DEPTH);
    if (mq.size() != 0) m_head = mq[0];
  endtask

  task automatic check_outputs();
    chk("ready", {63'd0, stu__pe__ready}, {63'd0, m_ready});
    chk("valid", {63'd0, stu__sys__valid}, {63'd0, mq.size() != 0});
    chk("cntl", {62'd0, stu__sys__cntl}, {62'd0, m_head.cntl});
    chk("type", {62'd0, stu__sys__type}, {62'd0, m_head.typ});
    chk("data", stu__sys__data, m_head.data);
    chk("oob", {32'd0, stu__sys__oob_data}, {32'd0, m_head.oob});
    chk("pkt_count", {48'd0, stu__sys__pkt_count}, {48'd0, m_pkt[15:0]});
    chk("framing_err", {63'd0, stu__sys__framing_err}, {63'd0, m_err});
  endtask

  function automatic tb_beat_t rnd_beat(input logic [1:0] c);
    tb_beat_t b;
    b.cntl = c;
    b.typ  = 2'($urandom_range(0, 3));
    b.data = {$urandom, $urandom};
    b.oob  = $urandom;
    return b;
  endfunction

  // Entered and left at posedge+1.
  task automatic cycle(input bit pv, input tb_beat_t b, input bit sr);
    pe__stu__valid    = pv;
    pe__stu__cntl     = b.cntl;
    pe__stu__type     = b.typ;
    pe__stu__data     = b.data;
    pe__stu__oob_data = b.oob;
    sys__stu__ready   = sr;
    @(negedge clk);
    check_outputs();
    model_edge(pv, b, sr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit sr);
    cycle(1'b0, rnd_beat(2'b00), sr);
  endtask

  task automatic do_reset();
    reset_poweron     = 1'b0;
    pe__stu__valid    = 1'b0;
    pe__stu__cntl     = '0;
    pe__stu__type     = '0;
    pe__stu__data     = '0;
    pe__stu__oob_data = '0;
    sys__stu__ready   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset_poweron = 1'b1;
  endtask

  typedef struct {
    bit          pv;
    logic [1:0]  cntl;
    logic [63:0] data;
    logic [31:0] oob;
    bit          sr;
    bit          e_valid;
    logic [1:0]  e_cntl;
    logic [63:0] e_data;
    logic [31:0] e_oob;
    logic [15:0] e_pkt;
    bit          e_err;
    bit          e_ready;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int pops;
    int rem;
    logic [1:0] c;
    bit pv, sr;

    // Single SOM_EOM then a 3-beat packet, expectations written out by hand.
    tbl[0] = '{1'b1, 2'b11, 64'hDEAD_BEEF, 32'h5, 1'b1, 1'b0, 2'b00, 64'h0,         32'h0, 16'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 2'b00, 64'h0,         32'h0, 1'b1, 1'b1, 2'b11, 64'hDEAD_BEEF, 32'h5, 16'd1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 2'b01, 64'h11,        32'hA, 1'b1, 1'b0, 2'b11, 64'hDEAD_BEEF, 32'h5, 16'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 2'b00, 64'h22,        32'hB, 1'b1, 1'b1, 2'b01, 64'h11,        32'hA, 16'd1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 2'b10, 64'h33,        32'hC, 1'b1, 1'b1, 2'b00, 64'h22,        32'hB, 16'd1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 2'b00, 64'h0,         32'h0, 1'b1, 1'b1, 2'b10, 64'h33,        32'hC, 16'd2, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 2'b00, 64'h0,         32'h0, 1'b1, 1'b0, 2'b10, 64'h33,        32'hC, 16'd2, 1'b0, 1'b1};

    do_reset();
    idle(1'b1);
    for (int i = 0; i < 7; i++) begin
      pe__stu__valid    = tbl[i].pv;
      pe__stu__cntl     = tbl[i].cntl;
      pe__stu__type     = 2'b01;
      pe__stu__data     = tbl[i].data;
      pe__stu__oob_data = tbl[i].oob;
      sys__stu__ready   = tbl[i].sr;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {63'd0, stu__sys__valid}, {63'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_cntl", i), {62'd0, stu__sys__cntl}, {62'd0, tbl[i].e_cntl});
      chk($sformatf("tbl%0d_data", i), stu__sys__data, tbl[i].e_data);
      chk($sformatf("tbl%0d_oob", i), {32'd0, stu__sys__oob_data}, {32'd0, tbl[i].e_oob});
      chk($sformatf("tbl%0d_pkt", i), {48'd0, stu__sys__pkt_count}, {48'd0, tbl[i].e_pkt});
      chk($sformatf("tbl%0d_err", i), {63'd0, stu__sys__framing_err}, {63'd0, tbl[i].e_err});
      chk($sformatf("tbl%0d_ready", i), {63'd0, stu__pe__ready}, {63'd0, tbl[i].e_ready});
      @(posedge clk);
      #1;
    end

    // Fill with consumer stalled, PE honouring ready; then drain.
    do_reset();
    idle(1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(m_ready, rnd_beat(i == 0 ? 2'b01 : 2'b00), 1'b0);
    end
    chk("full_ready_low", {63'd0, stu__pe__ready}, 64'd0);
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (stu__sys__valid) pops++;
      idle(1'b1);
    end
    chk("drain_count", pops, 64'd8);
    cycle(1'b1, rnd_beat(2'b10), 1'b1);
    repeat (2) idle(1'b1);

    // Near-full streaming with simultaneous push and pop.
    do_reset();
    idle(1'b0);
    for (int i = 0; i < 9; i++) cycle(m_ready, rnd_beat(i == 0 ? 2'b01 : 2'b00), 1'b0);
    for (int i = 0; i < 16; i++) cycle(m_ready, rnd_beat(2'b00), 1'b1);
    for (int i = 0; i < 10; i++) idle(1'b1);

    // MOM while idle, then SOM, SOM, EOM.
    do_reset();
    idle(1'b1);
    cycle(1'b1, rnd_beat(2'b00), 1'b1);
    cycle(1'b1, rnd_beat(2'b01), 1'b1);
    cycle(1'b1, rnd_beat(2'b01), 1'b1);
    cycle(1'b1, rnd_beat(2'b10), 1'b1);
    repeat (4) idle(1'b1);
    chk("seq_err_sticky", {63'd0, stu__sys__framing_err}, 64'd1);
    chk("seq_pkt_count", {48'd0, stu__sys__pkt_count}, 64'd1);

    // Asynchronous reset mid-packet with beats queued.
    do_reset();
    idle(1'b0);
    cycle(1'b1, rnd_beat(2'b11), 1'b0);
    cycle(1'b1, rnd_beat(2'b01), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_beat(2'b00), 1'b0);
    #2;
    reset_poweron = 1'b0;
    #1;
    chk("arst_valid", {63'd0, stu__sys__valid}, 64'd0);
    chk("arst_ready", {63'd0, stu__pe__ready}, 64'd0);
    chk("arst_pkt", {48'd0, stu__sys__pkt_count}, 64'd0);
    pe__stu__valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_poweron = 1'b1;
    idle(1'b1);
    cycle(1'b1, rnd_beat(2'b11), 1'b1);
    repeat (2) idle(1'b1);
    chk("arst_fresh_pkt", {48'd0, stu__sys__pkt_count}, 64'd1);

    // Random well-formed traffic.
    do_reset();
    idle(1'b1);
    rem = 0;
    for (int i = 0; i < 1500; i++) begin
      pv = m_ready && ($urandom_range(0, 3) != 0);
      sr = ((i / 40) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      c  = 2'b00;
      if (pv) begin
        if (rem == 0) begin
          rem = $urandom_range(1, 5);
          c   = (rem == 1) ? 2'b11 : 2'b01;
          rem = rem - 1;
        end else if (rem == 1) begin
          c   = 2'b10;
          rem = 0;
        end else begin
          rem = rem - 1;
        end
      end
      cycle(pv, rnd_beat(c), sr);
    end

    // Random framing and occasional protocol violations.
    for (int i = 0; i < 500; i++) begin
      pv = m_ready ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 15) == 0);
      cycle(pv, rnd_beat(2'($urandom_range(0, 3))), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 10; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
